// File: rtl/adder_share_arb.sv
// Round-robin arbiter sharing one combinational adder among NREQ requesters; 2-cycle accept-to-response latency, 3-cycle period.
// Backpressure: rsp_ready low holds the response and blocks all new grants until the handshake completes.
module adder_share_arb #(
  parameter int W = 8,
  parameter int NREQ = 4,
  localparam int ID_W = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [W-1:0]      add_a,
  output logic [W-1:0]      add_b,
  input  logic [W:0]        add_s,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ID_W-1:0]   rsp_id,
  output logic [W:0]        rsp_sum
);

  typedef enum logic [1:0] {IDLE, ADD, RESP} state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [W-1:0]    add_a_q, add_a_d;
  logic [W-1:0]    add_b_q, add_b_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [W:0]      rsp_sum_q, rsp_sum_d;

  logic            gnt_vld;
  logic [ID_W-1:0] gnt_id;

  // Search starts just after the last winner; ID_W-bit wrap is the modulo since NREQ is a power of two.
  always_comb begin
    logic [ID_W-1:0] cand;
    gnt_vld = 1'b0;
    gnt_id  = '0;
    cand    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = ptr_q + ID_W'(k);
      if (!gnt_vld && req_valid[cand]) begin
        gnt_vld = 1'b1;
        gnt_id  = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= ID_W'(NREQ - 1);
      add_a_q     <= '0;
      add_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          state_d  = ADD;
          ptr_d    = gnt_id;
          rsp_id_d = gnt_id;
          add_a_d  = req_a[int'(gnt_id)*W +: W];
          add_b_d  = req_b[int'(gnt_id)*W +: W];
        end
      end
      ADD: begin
        state_d     = RESP;
        rsp_sum_d   = add_s;
        rsp_valid_d = 1'b1;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && !rst && gnt_vld) begin
      req_ready[gnt_id] = 1'b1;
    end
  end

  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;

endmodule

// File: tb/tb_adder_share_arb.sv
// Bench for adder_share_arb: transaction-level model predicts grants and sums; a negedge monitor scores every cycle.
module tb_adder_share_arb;
  localparam int W = 8;
  localparam int NREQ = 4;
  localparam int ID_W = $clog2(NREQ);

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a, req_b;
  logic [W-1:0]      add_a, add_b;
  logic [W:0]        add_s;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [ID_W-1:0]   rsp_id;
  logic [W:0]        rsp_sum;

  always #5 clk = ~clk;

  assign add_s = {1'b0, add_a} + {1'b0, add_b};

  adder_share_arb #(.W(W), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .add_a(add_a), .add_b(add_b), .add_s(add_s),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum)
  );

  typedef struct {
    int id;
    int sum;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   m_ptr = NREQ - 1;
  bit   busy = 1'b0;
  bit   rst_prev = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int rr_pick(input int last, input logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  // Model: one transaction in flight; response due two cycles after accept; next grant only after the response handshake cycle.
  always @(negedge clk) begin
    int  g;
    bit  busy0;
    bit  exp_v;
    logic [NREQ-1:0] exp_rdy;
    exp_t e;
    cyc++;
    if (rst) begin
      chk("rst_req_ready", int'(req_ready), 0);
      if (rst_prev) begin
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_sum", int'(rsp_sum), 0);
        chk("rst_rsp_id", int'(rsp_id), 0);
      end
      exp_q.delete();
      busy  = 1'b0;
      m_ptr = NREQ - 1;
    end else begin
      busy0   = busy;
      exp_rdy = '0;
      g       = -1;
      if (!busy0 && req_valid != '0) begin
        g = rr_pick(m_ptr, req_valid);
        exp_rdy[g] = 1'b1;
      end
      chk("req_ready", int'(req_ready), int'(exp_rdy));
      exp_v = (exp_q.size() > 0) && (cyc >= exp_q[0].cyc + 2);
      chk("rsp_valid", int'(rsp_valid), int'(exp_v));
      if (exp_v && rsp_valid) begin
        chk("rsp_id", int'(rsp_id), exp_q[0].id);
        chk("rsp_sum", int'(rsp_sum), exp_q[0].sum);
        if (rsp_ready) begin
          void'(exp_q.pop_front());
          busy = 1'b0;
        end
      end
      if (g >= 0) begin
        e.id  = g;
        e.sum = int'(req_a[g*W +: W]) + int'(req_b[g*W +: W]);
        e.cyc = cyc;
        exp_q.push_back(e);
        m_ptr = g;
        busy  = 1'b1;
      end
    end
    rst_prev = rst;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input int a, input int b);
    req_a[i*W +: W] = W'(a);
    req_b[i*W +: W] = W'(b);
  endtask

  task automatic drain();
    int n;
    req_valid = '0;
    rsp_ready = 1'b1;
    n = 0;
    while ((exp_q.size() > 0 || busy) && n < 20) begin
      step();
      n++;
    end
    step();
    chk("drain_timeout", int'(exp_q.size() > 0 || busy), 0);
  endtask

  // Hold one requester valid until granted, then drop it; bounded wait.
  task automatic one_req(input int i, input int a, input int b);
    int n;
    set_ops(i, a, b);
    req_valid = '0;
    req_valid[i] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready[i] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("grant_timeout", int'(n >= 20), 0);
    step();
    req_valid = '0;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    req_valid = '1;
    rsp_ready = 1'b1;
    req_a = '0;
    req_b = '0;
    #1;
    step();
    step();
    rst = 1'b0;

    for (int i = 0; i < NREQ; i++) set_ops(i, i * 10, 1);
    for (int c = 0; c < 20; c++) step();
    drain();

    one_req(1, 5, 7);
    drain();
    one_req(0, 255, 255);
    drain();
    one_req(2, 100, 28);
    drain();
    one_req(3, 0, 0);
    drain();

    rsp_ready = 1'b0;
    one_req(3, 9, 9);
    n = 0;
    while (!rsp_valid && n < 10) begin
      step();
      n++;
    end
    chk("bp_rsp_timeout", int'(n >= 10), 0);
    for (int i = 0; i < NREQ; i++) set_ops(i, i + 40, 3);
    req_valid = '1;
    for (int c = 0; c < 5; c++) step();
    rsp_ready = 1'b1;
    for (int c = 0; c < 8; c++) step();
    drain();

    one_req(2, 77, 11);
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_valid = '1;
    for (int c = 0; c < 10; c++) step();
    drain();

    for (int c = 0; c < 400; c++) begin
      req_valid = NREQ'($urandom);
      req_a     = $urandom;
      req_b     = $urandom;
      rsp_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
    $fatal(1);
  end

endmodule
